// File: rtl/mrv1_lsu_pkg.sv
// Shared types and helpers for the mrv1 load/store unit.
// Holds the access-size enum, the outstanding-queue entry layout and the
// byte-lane helpers used for store formatting and load extraction.
package mrv1_lsu_pkg;

    localparam int LSU_LANES = 4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        ILL  = 2'd3
    } lsu_size_e;

    // Per-op state needed to format the response once it comes back.
    typedef struct packed {
        lsu_size_e  size;
        logic       sgn;
        logic [1:0] off;
        logic       we;
    } lsu_q_entry_t;

    function automatic logic lsu_misaligned(lsu_size_e size, logic [1:0] off);
        return (size == HALF && off[0]) || (size == WORD && off != 2'b00) || (size == ILL);
    endfunction

    function automatic logic [LSU_LANES-1:0] lsu_be(lsu_size_e size, logic [1:0] off);
        case (size)
            BYTE:    return 4'b0001 << off;
            HALF:    return 4'b0011 << off;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(lsu_size_e size, logic [31:0] d);
        case (size)
            BYTE:    return {LSU_LANES{d[7:0]}};
            HALF:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] lsu_extract(logic [31:0] rdata, lsu_size_e size,
                                                logic [1:0] off, logic sgn);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            BYTE:    return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            HALF:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/mrv1_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface mrv1_lsu_if;
    logic        dmem_req_vld_o;
    logic        dmem_req_rdy_i;
    logic [31:0] dmem_req_addr_o;
    logic        dmem_req_w_en_o;
    logic [3:0]  dmem_req_w_be_o;
    logic [31:0] dmem_req_w_data_o;
    logic        dmem_resp_vld_i;
    logic        dmem_resp_err_i;
    logic [31:0] dmem_resp_r_data_i;

    modport master (
        output dmem_req_vld_o, dmem_req_addr_o, dmem_req_w_en_o,
               dmem_req_w_be_o, dmem_req_w_data_o,
        input  dmem_req_rdy_i, dmem_resp_vld_i, dmem_resp_err_i, dmem_resp_r_data_i
    );

    modport slave (
        input  dmem_req_vld_o, dmem_req_addr_o, dmem_req_w_en_o,
               dmem_req_w_be_o, dmem_req_w_data_o,
        output dmem_req_rdy_i, dmem_resp_vld_i, dmem_resp_err_i, dmem_resp_r_data_i
    );
endinterface

// File: rtl/mrv1_fifo.sv
// Generic synchronous show-ahead FIFO with occupancy count.
// DEPTH_P must be a power of two so the pointers wrap naturally.
module mrv1_fifo #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 4,
    localparam int AW_LP  = $clog2(DEPTH_P)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               pop_i,
    output logic [WIDTH_P-1:0] data_o,
    output logic [AW_LP:0]     count_o,
    output logic               empty_o
);
    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [AW_LP-1:0]   wr_ptr_q;
    logic [AW_LP-1:0]   rd_ptr_q;
    logic [AW_LP:0]     count_q;
    logic               push_ok;
    logic               pop_ok;

    assign pop_ok  = pop_i & (count_q != '0);
    assign push_ok = push_i & ((count_q != (AW_LP+1)'(DEPTH_P)) | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mrv1_lsu.sv
// mrv1 pipelined multithreaded load/store unit.
// Computes src0+imm, sends aligned ops to dmem through a one-entry request
// slot, tracks them in an in-order queue and formats the responses.
// Misaligned ops never reach dmem; they complete with an error once all
// older ops have drained. Optional counters: define MRV1_LSU_STATS_EN.
module mrv1_lsu
    import mrv1_lsu_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int ITAG_WIDTH_P      = 3,
    parameter int NUM_TW_P          = 8,
    parameter int MAX_OUTSTANDING_P = 4,
    localparam int TID_WIDTH_LP     = $clog2(NUM_TW_P)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    lsu_req_i,
    output logic                    lsu_rdy_o,
    input  logic [DATA_WIDTH_P-1:0] lsu_src0_i,
    input  logic [DATA_WIDTH_P-1:0] lsu_imm_i,
    input  logic [DATA_WIDTH_P-1:0] lsu_w_data_i,
    input  logic                    lsu_w_en_i,
    input  logic [1:0]              lsu_size_i,
    input  logic                    lsu_signed_i,
    input  logic [ITAG_WIDTH_P-1:0] lsu_itag_i,
    input  logic [TID_WIDTH_LP-1:0] lsu_tid_i,
    output logic                    lsu_done_o,
    output logic [DATA_WIDTH_P-1:0] lsu_res_o,
    output logic                    lsu_err_o,
    output logic [ITAG_WIDTH_P-1:0] lsu_itag_o,
    output logic [TID_WIDTH_LP-1:0] lsu_tid_o,
    mrv1_lsu_if.master              dmem,
    output logic [31:0]             stat_ld_cnt_o,
    output logic [31:0]             stat_st_cnt_o,
    output logic [31:0]             stat_err_cnt_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING_P) + 1;
    localparam int ENT_W = ITAG_WIDTH_P + TID_WIDTH_LP + $bits(lsu_q_entry_t);

    logic [DATA_WIDTH_P-1:0] addr;
    lsu_size_e               req_size;
    logic                    misaligned, accept, push, pop, mis_done;
    logic [CNT_W-1:0]        q_count;
    logic                    q_empty;
    lsu_q_entry_t            push_ent, head_ent;
    logic [ENT_W-1:0]        push_data, head_data;
    logic [ITAG_WIDTH_P-1:0] head_itag;
    logic [TID_WIDTH_LP-1:0] head_tid;

    logic                    rdy_en_q;
    logic                    req_vld_q;
    logic [DATA_WIDTH_P-1:0] req_addr_q;
    logic                    req_we_q;
    logic [3:0]              req_be_q;
    logic [DATA_WIDTH_P-1:0] req_wdata_q;
    logic                    pend_err_q;
    logic [ITAG_WIDTH_P-1:0] pend_itag_q;
    logic [TID_WIDTH_LP-1:0] pend_tid_q;
    logic                    done_q;
    logic                    err_q;
    logic [DATA_WIDTH_P-1:0] res_q;
    logic [ITAG_WIDTH_P-1:0] itag_q;
    logic [TID_WIDTH_LP-1:0] tid_q;

    assign addr       = lsu_src0_i + lsu_imm_i;
    assign req_size   = lsu_size_e'(lsu_size_i);
    assign misaligned = lsu_misaligned(req_size, addr[1:0]);

    // rdy_en_q keeps ready low while reset is held and for the reset cycle itself.
    assign lsu_rdy_o = rdy_en_q & ~pend_err_q & (~req_vld_q | dmem.dmem_req_rdy_i)
                     & (q_count < CNT_W'(MAX_OUTSTANDING_P));
    assign accept    = lsu_req_i & lsu_rdy_o;
    assign push      = accept & ~misaligned;
    assign pop       = dmem.dmem_resp_vld_i & ~q_empty;
    // Error completes only once every older op has left both slot and queue.
    assign mis_done  = pend_err_q & q_empty & ~req_vld_q;

    assign push_ent  = '{size: req_size, sgn: lsu_signed_i, off: addr[1:0], we: lsu_w_en_i};
    assign push_data = {lsu_itag_i, lsu_tid_i, push_ent};
    assign {head_itag, head_tid, head_ent} = head_data;

    mrv1_fifo #(
        .WIDTH_P (ENT_W),
        .DEPTH_P (MAX_OUTSTANDING_P)
    ) u_outstanding_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    // Ready enable: rises on the first clock after reset is released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdy_en_q <= 1'b0;
        else       rdy_en_q <= 1'b1;
    end

    // Request slot: loaded on aligned accept, held stable until dmem takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_vld_q   <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
        end else if (push) begin
            req_vld_q   <= 1'b1;
            req_addr_q  <= {addr[DATA_WIDTH_P-1:2], 2'b00};
            req_we_q    <= lsu_w_en_i;
            req_be_q    <= lsu_be(req_size, addr[1:0]);
            req_wdata_q <= lsu_wdata(req_size, lsu_w_data_i);
        end else if (req_vld_q & dmem.dmem_req_rdy_i) begin
            req_vld_q   <= 1'b0;
        end
    end

    // Pending misaligned op: blocks issue until it has completed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_err_q  <= 1'b0;
            pend_itag_q <= '0;
            pend_tid_q  <= '0;
        end else if (accept & misaligned) begin
            pend_err_q  <= 1'b1;
            pend_itag_q <= lsu_itag_i;
            pend_tid_q  <= lsu_tid_i;
        end else if (mis_done) begin
            pend_err_q  <= 1'b0;
        end
    end

    // Completion port: one registered done pulse per response or misaligned op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            res_q  <= '0;
            itag_q <= '0;
            tid_q  <= '0;
        end else begin
            done_q <= pop | mis_done;
            err_q  <= 1'b0;
            res_q  <= '0;
            if (pop) begin
                itag_q <= head_itag;
                tid_q  <= head_tid;
                err_q  <= dmem.dmem_resp_err_i;
                if (!dmem.dmem_resp_err_i && !head_ent.we)
                    res_q <= lsu_extract(dmem.dmem_resp_r_data_i, head_ent.size,
                                         head_ent.off, head_ent.sgn);
            end else if (mis_done) begin
                itag_q <= pend_itag_q;
                tid_q  <= pend_tid_q;
                err_q  <= 1'b1;
            end
        end
    end

    assign lsu_done_o = done_q;
    assign lsu_err_o  = err_q;
    assign lsu_res_o  = res_q;
    assign lsu_itag_o = itag_q;
    assign lsu_tid_o  = tid_q;

    assign dmem.dmem_req_vld_o    = req_vld_q;
    assign dmem.dmem_req_addr_o   = req_addr_q;
    assign dmem.dmem_req_w_en_o   = req_we_q;
    assign dmem.dmem_req_w_be_o   = req_be_q;
    assign dmem.dmem_req_w_data_o = req_wdata_q;

`ifdef MRV1_LSU_STATS_EN
    logic        done_we_q;
    logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;

    // Remember whether the completing op was a store, for classification.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) done_we_q <= 1'b0;
        else       done_we_q <= pop & head_ent.we;
    end

    // Saturating completion counters, sampled while done is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (done_q) begin
            if (err_q) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end else if (done_we_q) begin
                if (st_cnt_q != '1) st_cnt_q <= st_cnt_q + 1'b1;
            end else begin
                if (ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + 1'b1;
            end
        end
    end

    assign stat_ld_cnt_o  = ld_cnt_q;
    assign stat_st_cnt_o  = st_cnt_q;
    assign stat_err_cnt_o = err_cnt_q;
`else
    assign stat_ld_cnt_o  = '0;
    assign stat_st_cnt_o  = '0;
    assign stat_err_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    resp_needs_outstanding_a: assert property (@(posedge clk_i) disable iff (rst_i)
        dmem.dmem_resp_vld_i |-> !q_empty);
`endif

endmodule

// File: tb/tb_mrv1_lsu.sv
// Testbench for mrv1_lsu: directed scenarios plus a randomized run checked
// against a queue-based reference model of in-order completion.
module tb_mrv1_lsu;
    localparam int IW   = 3;
    localparam int NT   = 8;
    localparam int TW   = $clog2(NT);
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          rdy;
    logic [31:0]   src0 = '0, imm = '0, wdata = '0;
    logic          wen = 1'b0;
    logic [1:0]    size = '0;
    logic          sgn = 1'b0;
    logic [IW-1:0] itag = '0;
    logic [TW-1:0] tid = '0;
    logic          done, err;
    logic [31:0]   res;
    logic [IW-1:0] itag_o;
    logic [TW-1:0] tid_o;
    logic [31:0]   st_ld, st_st, st_err;

    mrv1_lsu_if bus ();

    mrv1_lsu #(
        .DATA_WIDTH_P(32), .ITAG_WIDTH_P(IW), .NUM_TW_P(NT), .MAX_OUTSTANDING_P(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(req), .lsu_rdy_o(rdy),
        .lsu_src0_i(src0), .lsu_imm_i(imm), .lsu_w_data_i(wdata),
        .lsu_w_en_i(wen), .lsu_size_i(size), .lsu_signed_i(sgn),
        .lsu_itag_i(itag), .lsu_tid_i(tid),
        .lsu_done_o(done), .lsu_res_o(res), .lsu_err_o(err),
        .lsu_itag_o(itag_o), .lsu_tid_o(tid_o),
        .dmem(bus.master),
        .stat_ld_cnt_o(st_ld), .stat_st_cnt_o(st_st), .stat_err_cnt_o(st_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] itag;
        logic [TW-1:0] tid;
        bit            we;
        int            sz;
        bit            sgn;
        logic [31:0]   addr;
        logic [31:0]   wd;
        bit            mis;
        logic [31:0]   rdata;
        bit            berr;
    } op_t;

    op_t ops [4096];
    int  nops = 0;
    int  exp_q[$];
    int  req_q[$];
    int  infl_q[$];
    int  m_cnt = 0;
    bit  m_pend = 0;
    int  n_ld = 0, n_st = 0, n_err = 0;

    // ---------------- reference model ----------------
    function automatic int nbytes(int sz);
        return 1 << sz;
    endfunction

    function automatic bit ref_mis(int sz, logic [31:0] a);
        if (sz == 3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(int sz, logic [31:0] a);
        logic [3:0] m;
        int lo;
        m  = '0;
        lo = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= lo && i < lo + nbytes(sz)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(int sz, logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] rd, int sz, int off, bit s);
        logic [63:0] v, full;
        full = 64'd1 << (8 * nbytes(sz));
        v    = ({32'd0, rd} >> (8 * off)) % full;
        if (s && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(bit we, int sz, bit sg, logic [31:0] s0, logic [31:0] im,
                             logic [31:0] wd, logic [IW-1:0] it, logic [TW-1:0] td);
        req = 1'b1; wen = we; size = 2'(sz); sgn = sg;
        src0 = s0; imm = im; wdata = wd; itag = it; tid = td;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        bus.dmem_req_rdy_i = 1'b0; bus.dmem_resp_vld_i = 1'b0;
        bus.dmem_resp_err_i = 1'b0; bus.dmem_resp_r_data_i = '0;
        rst = 1'b1;
        #2;
        checks++;
        if ({done, err, rdy, bus.dmem_req_vld_o, bus.dmem_req_w_en_o} !== 5'b0 ||
            res !== 0 || itag_o !== 0 || tid_o !== 0 || bus.dmem_req_addr_o !== 0 ||
            bus.dmem_req_w_be_o !== 0 || bus.dmem_req_w_data_o !== 0 ||
            st_ld !== 0 || st_st !== 0 || st_err !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b err=%b rdy=%b vld=%b res=%h expected all zero",
                     done, err, rdy, bus.dmem_req_vld_o, res);
        end
        step; step;
        rst = 1'b0;
        step;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_reset: got %b expected 1", rdy);
        end
        $display("test_reset done");
    endtask

    task automatic test_word_load;
        bus.dmem_req_rdy_i = 1'b1;
        drive_req(0, 2, 0, 32'h1000, 32'd4, 32'h0, 3'd5, 3'd2);
        step;
        req = 1'b0;
        checks++;
        if (bus.dmem_req_vld_o !== 1'b1 || bus.dmem_req_addr_o !== 32'h1004 ||
            bus.dmem_req_w_be_o !== 4'hF || bus.dmem_req_w_en_o !== 1'b0) begin
            errors++;
            $display("FAIL word_load_req: got vld=%b addr=%h be=%h we=%b expected 1 00001004 f 0",
                     bus.dmem_req_vld_o, bus.dmem_req_addr_o, bus.dmem_req_w_be_o, bus.dmem_req_w_en_o);
        end
        step; step;
        bus.dmem_resp_vld_i = 1'b1; bus.dmem_resp_r_data_i = 32'hDEADBEEF;
        step;
        bus.dmem_resp_vld_i = 1'b0;
        checks++;
        if (done !== 1'b1 || res !== 32'hDEADBEEF || itag_o !== 3'd5 || tid_o !== 3'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL word_load_done: got done=%b res=%h itag=%0d tid=%0d err=%b expected 1 deadbeef 5 2 0",
                     done, res, itag_o, tid_o, err);
        end
        step;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 0", done);
        end
        $display("test_word_load done");
    endtask

    task automatic test_byte_load;
        logic [31:0] exp_r;
        for (int s = 1; s >= 0; s--) begin
            exp_r = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
            drive_req(0, 0, bit'(s), 32'h1000, 32'd3, 32'h0, IW'(s + 1), TW'(s));
            step;
            req = 1'b0;
            checks++;
            if (bus.dmem_req_w_be_o !== 4'h8 || bus.dmem_req_addr_o !== 32'h1000) begin
                errors++;
                $display("FAIL byte_load_be: got be=%h addr=%h expected 8 00001000",
                         bus.dmem_req_w_be_o, bus.dmem_req_addr_o);
            end
            step;
            bus.dmem_resp_vld_i = 1'b1; bus.dmem_resp_r_data_i = 32'h80FFFFFF;
            step;
            bus.dmem_resp_vld_i = 1'b0;
            checks++;
            if (done !== 1'b1 || res !== exp_r || err !== 1'b0) begin
                errors++;
                $display("FAIL byte_load_res signed=%0d: got done=%b res=%h expected 1 %h", s, done, res, exp_r);
            end
            step;
        end
        $display("test_byte_load done");
    endtask

    task automatic test_half_store;
        drive_req(1, 1, 0, 32'h2000, 32'd2, 32'h1234ABCD, 3'd3, 3'd4);
        step;
        req = 1'b0;
        checks++;
        if (bus.dmem_req_w_be_o !== 4'hC || bus.dmem_req_w_data_o !== 32'hABCDABCD ||
            bus.dmem_req_w_en_o !== 1'b1 || bus.dmem_req_addr_o !== 32'h2000) begin
            errors++;
            $display("FAIL half_store_req: got be=%h data=%h we=%b addr=%h expected c abcdabcd 1 00002000",
                     bus.dmem_req_w_be_o, bus.dmem_req_w_data_o, bus.dmem_req_w_en_o, bus.dmem_req_addr_o);
        end
        step;
        bus.dmem_resp_vld_i = 1'b1; bus.dmem_resp_r_data_i = 32'hFFFFFFFF;
        step;
        bus.dmem_resp_vld_i = 1'b0;
        checks++;
        if (done !== 1'b1 || res !== 32'h0 || err !== 1'b0 || itag_o !== 3'd3 || tid_o !== 3'd4) begin
            errors++;
            $display("FAIL half_store_done: got done=%b res=%h err=%b itag=%0d tid=%0d expected 1 0 0 3 4",
                     done, res, err, itag_o, tid_o);
        end
        step;
        $display("test_half_store done");
    endtask

    task automatic test_fill_queue;
        for (int i = 0; i < MAXO; i++) begin
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL fill_rdy_%0d: got %b expected 1", i, rdy);
            end
            drive_req(0, 2, 0, 32'h100, 32'(4 * i), 32'h0, IW'(i), TW'(i));
            step;
        end
        req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdy !== 1'b0) begin
                errors++;
                $display("FAIL full_rdy_%0d: got %b expected 0", k, rdy);
            end
            step;
        end
        for (int i = 0; i < MAXO; i++) begin
            bus.dmem_resp_vld_i = 1'b1; bus.dmem_resp_r_data_i = 32'h11111111 * i;
            step;
            checks++;
            if (done !== 1'b1 || itag_o !== IW'(i) || tid_o !== TW'(i) || res !== 32'h11111111 * i) begin
                errors++;
                $display("FAIL fill_done_%0d: got done=%b itag=%0d tid=%0d res=%h expected 1 %0d %0d %h",
                         i, done, itag_o, tid_o, res, i, i, 32'h11111111 * i);
            end
        end
        bus.dmem_resp_vld_i = 1'b0;
        step;
        $display("test_fill_queue done");
    endtask

    task automatic test_misaligned;
        drive_req(0, 2, 0, 32'h400, 32'd0, 32'h0, 3'd1, 3'd1);
        step;
        drive_req(0, 2, 0, 32'h404, 32'd0, 32'h0, 3'd2, 3'd1);
        step;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL mis_pre_rdy: got %b expected 1", rdy);
        end
        drive_req(0, 2, 0, 32'h3000, 32'd1, 32'h0, 3'd6, 3'd7);
        step;
        req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy !== 1'b0 || bus.dmem_req_vld_o !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL mis_blocked_%0d: got rdy=%b vld=%b done=%b expected 0 0 0",
                         k, rdy, bus.dmem_req_vld_o, done);
            end
            step;
        end
        for (int i = 1; i <= 2; i++) begin
            bus.dmem_resp_vld_i = 1'b1; bus.dmem_resp_r_data_i = 32'h0000_0100 * i;
            step;
            checks++;
            if (done !== 1'b1 || itag_o !== IW'(i) || err !== 1'b0) begin
                errors++;
                $display("FAIL mis_older_done_%0d: got done=%b itag=%0d err=%b expected 1 %0d 0",
                         i, done, itag_o, err, i);
            end
        end
        bus.dmem_resp_vld_i = 1'b0;
        step;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || res !== 32'h0 || itag_o !== 3'd6 || tid_o !== 3'd7 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL mis_done: got done=%b err=%b res=%h itag=%0d tid=%0d rdy=%b expected 1 1 0 6 7 1",
                     done, err, res, itag_o, tid_o, rdy);
        end
        step;
        $display("test_misaligned done");
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) begin
            drive_req(0, 2, 0, 32'h800, 32'(4 * i), 32'h0, IW'(i), 3'd0);
            step;
        end
        req = 1'b0;
        step;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({done, err, rdy, bus.dmem_req_vld_o} !== 4'b0 || res !== 0 || itag_o !== 0 || tid_o !== 0) begin
            errors++;
            $display("FAIL async_reset: got done=%b err=%b rdy=%b vld=%b res=%h expected all zero",
                     done, err, rdy, bus.dmem_req_vld_o, res);
        end
        bus.dmem_resp_vld_i = 1'b1; bus.dmem_resp_r_data_i = 32'h12345678;
        step;
        bus.dmem_resp_vld_i = 1'b0;
        step;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL stray_resp_done_%0d: got %b expected 0", k, done);
            end
        end
        checks++;
        if (rdy !== 1'b1 || bus.dmem_req_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b expected 1 0", rdy, bus.dmem_req_vld_o);
        end
        $display("test_async_reset done");
    endtask

    // One cycle of the randomized scenario; entered #1 after a rising edge.
    task automatic rand_cycle(int ip, int dp, int rp);
        int  id;
        bit  do_pop, exp_rdy, exp_vld, e_err;
        logic [31:0] e_res, r;

        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rand_done: got unexpected done itag=%0d expected none", itag_o);
            end else begin
                id = exp_q.pop_front();
                e_err = ops[id].mis || ops[id].berr;
                e_res = (e_err || ops[id].we) ? 32'h0
                      : ref_load(ops[id].rdata, ops[id].sz, int'(ops[id].addr % 4), ops[id].sgn);
                if (itag_o !== ops[id].itag || tid_o !== ops[id].tid || err !== e_err || res !== e_res) begin
                    errors++;
                    $display("FAIL rand_done op%0d: got itag=%0d tid=%0d err=%b res=%h expected %0d %0d %b %h",
                             id, itag_o, tid_o, err, res, ops[id].itag, ops[id].tid, e_err, e_res);
                end else begin
                    $display("op%0d done itag=%0d tid=%0d err=%b res=%h", id, itag_o, tid_o, err, res);
                end
                if (e_err) n_err++;
                else if (ops[id].we) n_st++;
                else n_ld++;
                if (ops[id].mis) m_pend = 0;
            end
        end

        do_pop = 0;
        if (infl_q.size() > 0 && ($urandom % 100) < rp) begin
            id = infl_q.pop_front();
            ops[id].rdata = $urandom;
            ops[id].berr  = ($urandom % 8) == 0;
            bus.dmem_resp_vld_i    = 1'b1;
            bus.dmem_resp_err_i    = ops[id].berr;
            bus.dmem_resp_r_data_i = ops[id].rdata;
            do_pop = 1;
        end else begin
            bus.dmem_resp_vld_i    = 1'b0;
            bus.dmem_resp_err_i    = 1'b0;
            bus.dmem_resp_r_data_i = $urandom;
        end
        bus.dmem_req_rdy_i = ($urandom % 100) < dp;
        req = 1'b0;
        #1;

        exp_vld = req_q.size() != 0;
        exp_rdy = !m_pend && (!exp_vld || bus.dmem_req_rdy_i) && (m_cnt < MAXO);
        checks++;
        if (rdy !== exp_rdy || bus.dmem_req_vld_o !== exp_vld) begin
            errors++;
            $display("FAIL rand_rdy_vld: got rdy=%b vld=%b expected %b %b", rdy, bus.dmem_req_vld_o, exp_rdy, exp_vld);
        end

        if (bus.dmem_req_vld_o && bus.dmem_req_rdy_i && req_q.size() != 0) begin
            id = req_q.pop_front();
            checks++;
            if (bus.dmem_req_addr_o !== (ops[id].addr & 32'hFFFFFFFC) ||
                bus.dmem_req_w_be_o !== ref_be(ops[id].sz, ops[id].addr) ||
                bus.dmem_req_w_en_o !== ops[id].we ||
                (ops[id].we && bus.dmem_req_w_data_o !== ref_wdata(ops[id].sz, ops[id].wd))) begin
                errors++;
                $display("FAIL rand_req op%0d: got addr=%h be=%h we=%b data=%h expected %h %h %b %h",
                         id, bus.dmem_req_addr_o, bus.dmem_req_w_be_o, bus.dmem_req_w_en_o,
                         bus.dmem_req_w_data_o, ops[id].addr & 32'hFFFFFFFC,
                         ref_be(ops[id].sz, ops[id].addr), ops[id].we, ref_wdata(ops[id].sz, ops[id].wd));
            end
            infl_q.push_back(id);
        end

        if (rdy && ($urandom % 100) < ip && nops < 4096) begin
            id = nops++;
            r = $urandom % 16;
            ops[id].sz   = (r < 5) ? 0 : (r < 10) ? 1 : (r < 15) ? 2 : 3;
            ops[id].we   = $urandom % 2;
            ops[id].sgn  = $urandom % 2;
            ops[id].itag = IW'($urandom);
            ops[id].tid  = TW'($urandom);
            ops[id].wd   = $urandom;
            r = $urandom & 32'hFFFFFFFC;
            e_res = (($urandom % 2) != 0) ? 32'($urandom_range(0, 3) * 4) : 32'($urandom_range(0, 15));
            if (($urandom % 16) == 0) e_res = $urandom;
            ops[id].addr = r + e_res;
            ops[id].mis  = ref_mis(ops[id].sz, ops[id].addr);
            drive_req(ops[id].we, ops[id].sz, ops[id].sgn, r, e_res, ops[id].wd, ops[id].itag, ops[id].tid);
            exp_q.push_back(id);
            if (ops[id].mis) m_pend = 1;
            else begin
                req_q.push_back(id);
                m_cnt++;
            end
        end
        if (do_pop) m_cnt--;
        step;
    endtask

    task automatic test_random(int ncyc, int ip, int dp, int rp);
        for (int c = 0; c < ncyc; c++) rand_cycle(ip, dp, rp);
        $display("test_random ip=%0d dp=%0d rp=%0d done", ip, dp, rp);
    endtask

    task automatic test_drain;
        for (int c = 0; c < 200 && (exp_q.size() != 0 || done); c++) rand_cycle(0, 100, 100);
        req = 1'b0;
        bus.dmem_resp_vld_i = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d ops pending expected 0", exp_q.size());
        end
        step; step;
        checks++;
`ifdef MRV1_LSU_STATS_EN
        if (st_ld !== 32'(n_ld) || st_st !== 32'(n_st) || st_err !== 32'(n_err)) begin
            errors++;
            $display("FAIL stats: got ld=%0d st=%0d err=%0d expected %0d %0d %0d",
                     st_ld, st_st, st_err, n_ld, n_st, n_err);
        end
`else
        if (st_ld !== 32'd0 || st_st !== 32'd0 || st_err !== 32'd0) begin
            errors++;
            $display("FAIL stats_tied: got ld=%0d st=%0d err=%0d expected 0 0 0", st_ld, st_st, st_err);
        end
`endif
        $display("test_drain done: %0d loads %0d stores %0d errors completed", n_ld, n_st, n_err);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_fill_queue();
        test_misaligned();
        test_async_reset();
        test_random(500, 60, 70, 50);
        test_random(300, 100, 100, 90);
        test_random(300, 80, 30, 20);
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
